// File: rtl/drive_phase_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_phase_pkg                                                          |
// | Shared constants, types and helpers for the drive PHI2 phase generator.  |
// |                                                                          |
// | Contents:                                                                |
// |   DEF_HW / DEF_CW   default half-length field and cycle counter widths   |
// |   DEF_HALF_LEN      reset half-period (1 MHz drive at a 16-ce period)    |
// |   FAST_HALF_LEN     half-period for the 2 MHz drive mode                 |
// |   phase_evt_t       registered strobe pair of one channel                |
// |   clamp_half_len    maps a programmed half-length of 0 to 1              |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package drive_phase_pkg;

  localparam int DEF_HW        = 4;
  localparam int DEF_CW        = 32;
  localparam int DEF_HALF_LEN  = 8;
  localparam int FAST_HALF_LEN = 4;

  // Registered strobe pair: start and end of the PHI2 high half.
  typedef struct packed {
    logic rise;
    logic fall;
  } phase_evt_t;

  // A half-period of zero ce pulses cannot exist; the shortest legal one is 1.
  function automatic int unsigned clamp_half_len(input int unsigned raw);
    return (raw == 0) ? 1 : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drive_phase_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_phase_chan                                                         |
// | One drive phase channel: ce counter, active half length, cycle-aligned   |
// | pause, registered PHI2 rise/fall strobes and a completed-cycle counter.  |
// |                                                                          |
// | Ports:                                                                   |
// |   clk, reset   system clock, synchronous active-high reset               |
// |   ce           base clock-enable, the divider advances only on ce        |
// |   resync       restart this channel at phase 0                           |
// |   pause        pause request (level)                                     |
// |   half_len     half-period in ce pulses (0 behaves as 1)                 |
// |   p2_h_r       one-clk strobe, start of PHI2 high                        |
// |   p2_h_f       one-clk strobe, end of PHI2 high                          |
// |   paused       channel is halted for the current cycle                   |
// |   cycles       completed PHI2 cycles, wrapping                           |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module drive_phase_chan
  import drive_phase_pkg::*;
#(
  parameter int HW = DEF_HW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          resync,
  input  logic          pause,
  input  logic [HW-1:0] half_len,
  output logic          p2_h_r,
  output logic          p2_h_f,
  output logic          paused,
  output logic [CW-1:0] cycles
);

  // cnt runs 0..2L-1, so it needs one bit more than the half length.
  logic [HW:0]   cnt_q, cnt_d;
  logic [HW-1:0] len_q, len_d;
  logic          halted_q, halted_d;
  logic          pause_q, pause_d;
  phase_evt_t    evt_q, evt_d;
  logic [CW-1:0] cycles_q, cycles_d;

  logic [HW-1:0] len_load;
  logic [HW:0]   last_cnt;
  logic          at_rise;
  logic          at_fall;
  logic          at_last;

  assign len_load = HW'(clamp_half_len(32'(half_len)));
  assign last_cnt = {len_q, 1'b0} - (HW+1)'(1);
  assign at_rise  = (cnt_q == '0);
  assign at_fall  = (cnt_q == {1'b0, len_q});
  assign at_last  = (cnt_q == last_cnt);

  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    halted_d = halted_q;
    pause_d  = pause;
    evt_d    = '0;
    cycles_d = cycles_q;

    if (resync) begin
      // Restart at phase 0; a pending fall of the interrupted cycle is
      // dropped, so it never reaches cycles. halted is deliberately kept.
      cnt_d = '0;
      len_d = len_load;
    end else if (ce) begin
      if (at_last) begin
        // Half length only changes at a cycle boundary, so no half-cycle is
        // ever shortened or stretched by a reprogramming.
        cnt_d = '0;
        len_d = len_load;
      end else begin
        cnt_d = cnt_q + (HW+1)'(1);
      end

      // The pause decision is taken once per cycle, at its first ce; the
      // counter keeps running while halted so phase is preserved.
      if (at_rise) begin
        halted_d   = pause_q;
        evt_d.rise = ~pause_q;
      end

      // Rise and fall positions never coincide because L >= 1, so halted_q
      // here is the decision made at the start of this same cycle.
      if (at_fall) begin
        evt_d.fall = ~halted_q;
      end

      if (evt_d.fall) begin
        cycles_d = cycles_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      len_q    <= HW'(DEF_HALF_LEN);
      halted_q <= 1'b0;
      pause_q  <= 1'b0;
      evt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      halted_q <= halted_d;
      pause_q  <= pause_d;
      evt_q    <= evt_d;
      cycles_q <= cycles_d;
    end
  end

  assign p2_h_r = evt_q.rise;
  assign p2_h_f = evt_q.fall;
  assign paused = halted_q;
  assign cycles = cycles_q;

endmodule
`default_nettype wire

// File: rtl/drive_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_phase_gen                                                          |
// | Multi-channel drive PHI2 phase generator. Derives per-drive rise/fall    |
// | half-cycle strobes from the system clock-enable, each channel with its   |
// | own runtime-programmable half-period, pause and cycle counter.           |
// |                                                                          |
// | Ports:                                                                   |
// |   clk, reset   system clock, synchronous active-high reset               |
// |   ce           base clock-enable shared by all channels                  |
// |   resync       restarts every channel at phase 0 on the same clk         |
// |   pause        [CHANNELS] per-channel pause request                      |
// |   half_len     [CHANNELS*HW] per-channel half-period, channel 0 in LSBs  |
// |   p2_h_r       [CHANNELS] start-of-PHI2-high strobes                     |
// |   p2_h_f       [CHANNELS] end-of-PHI2-high strobes                       |
// |   paused       [CHANNELS] channel halted for the current cycle           |
// |   cycles       [CHANNELS*CW] completed PHI2 cycles, channel 0 in LSBs    |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module drive_phase_gen
  import drive_phase_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int HW       = DEF_HW,
  parameter int CW       = DEF_CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   resync,
  input  logic [CHANNELS-1:0]    pause,
  input  logic [CHANNELS*HW-1:0] half_len,
  output logic [CHANNELS-1:0]    p2_h_r,
  output logic [CHANNELS-1:0]    p2_h_f,
  output logic [CHANNELS-1:0]    paused,
  output logic [CHANNELS*CW-1:0] cycles
);

  // resync goes to every channel unregistered so all of them restart on the
  // same clk and their next rise strobes line up exactly.
  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      drive_phase_chan #(
        .HW (HW),
        .CW (CW)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .resync   (resync),
        .pause    (pause[ch]),
        .half_len (half_len[ch*HW +: HW]),
        .p2_h_r   (p2_h_r[ch]),
        .p2_h_f   (p2_h_f[ch]),
        .paused   (paused[ch]),
        .cycles   (cycles[ch*CW +: CW])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_drive_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_drive_phase_gen                                                       |
// | Self-checking bench for drive_phase_gen with two channels and a 4-bit    |
// | cycle counter. Expected outputs are queued when stimulus is driven and   |
// | compared after the clock edge that produces them.                        |
// |                                                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_drive_phase_gen;

  localparam int CH = 2;
  localparam int HW = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ce = 1'b0;
  logic             resync = 1'b0;
  logic [CH-1:0]    pause = '0;
  logic [CH*HW-1:0] half_len = {4'd8, 4'd8};
  logic [CH-1:0]    p2_h_r;
  logic [CH-1:0]    p2_h_f;
  logic [CH-1:0]    paused;
  logic [CH*CW-1:0] cycles;

  drive_phase_gen #(
    .CHANNELS (CH),
    .HW       (HW),
    .CW       (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .resync   (resync),
    .pause    (pause),
    .half_len (half_len),
    .p2_h_r   (p2_h_r),
    .p2_h_f   (p2_h_f),
    .paused   (paused),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    r;
    logic [CH-1:0]    f;
    logic [CH-1:0]    p;
    logic [CH*CW-1:0] cyc;
  } exp_t;

  typedef struct {
    bit       rst;
    bit       ce;
    bit       rs;
    bit       r;
    bit       f;
    bit [3:0] cyc;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   tick_no = 0;

  // reference state per channel
  int m_cnt [CH];
  int m_len [CH];
  bit m_halt[CH];
  bit m_pq  [CH];
  int m_cyc [CH];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s tick=%0d got=%0h want=%0h", name, tick_no, act, want);
    end
  endtask

  // Next-clk outputs derived from the current inputs and model state.
  task automatic model_step(output exp_t e);
    e = '{default: '0};
    for (int c = 0; c < CH; c++) begin
      int hl;
      int ld;
      bit r;
      bit f;
      hl = int'(half_len[c*HW +: HW]);
      ld = (hl == 0) ? 1 : hl;
      r = 1'b0;
      f = 1'b0;
      if (reset) begin
        m_cnt[c] = 0; m_len[c] = 8; m_halt[c] = 0; m_pq[c] = 0; m_cyc[c] = 0;
      end else begin
        if (resync) begin
          m_cnt[c] = 0;
          m_len[c] = ld;
        end else if (ce) begin
          if (m_cnt[c] == 0) begin
            m_halt[c] = m_pq[c];
            r = !m_halt[c];
          end
          if (m_cnt[c] == m_len[c]) f = !m_halt[c];
          if (f) m_cyc[c] = (m_cyc[c] + 1) % (1 << CW);
          m_cnt[c] = m_cnt[c] + 1;
          if (m_cnt[c] == 2 * m_len[c]) begin
            m_cnt[c] = 0;
            m_len[c] = ld;
          end
        end
        m_pq[c] = pause[c];
      end
      e.r[c] = r;
      e.f[c] = f;
      e.p[c] = m_halt[c];
      e.cyc[c*CW +: CW] = CW'(m_cyc[c]);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty tick=%0d got=none want=entry", tick_no);
      return;
    end
    e = sb.pop_front();
    cmp("p2_h_r", 32'(p2_h_r), 32'(e.r));
    cmp("p2_h_f", 32'(p2_h_f), 32'(e.f));
    cmp("paused", 32'(paused), 32'(e.p));
    cmp("cycles", 32'(cycles), 32'(e.cyc));
  endtask

  // One clk: queue the expectation (model or hand-written row), then compare.
  task automatic tick_x(input bit use_row, input exp_t row);
    exp_t e;
    model_step(e);
    sb.push_back(use_row ? row : e);
    @(posedge clk);
    #1;
    check_out();
    tick_no++;
  endtask

  task automatic tick();
    exp_t dummy;
    dummy = '{default: '0};
    tick_x(1'b0, dummy);
  endtask

  // ce every clk until the chosen strobe appears on channel c; n = clks used.
  task automatic wait_strobe(input int c, input bit fall, input int limit, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    ce = 1'b1;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = fall ? p2_h_f[c] : p2_h_r[c];
    end
    if (!seen) n = -1;
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    int s;

    // ---- reset state ----
    reset = 1'b1;
    tick();
    tick();
    cmp("reset_outputs", {p2_h_r, p2_h_f, paused, cycles}, 32'd0);
    reset = 1'b0;

    // ---- table: half_len = 0 behaves as L = 1, resync vs ce ----
    //            rst ce rs  r  f  cyc
    tbl[0]  = '{1, 0, 0, 0, 0, 4'd0};
    tbl[1]  = '{0, 1, 1, 0, 0, 4'd0};  // resync wins, ce not counted
    tbl[2]  = '{0, 1, 0, 1, 0, 4'd0};
    tbl[3]  = '{0, 1, 0, 0, 1, 4'd1};
    tbl[4]  = '{0, 0, 0, 0, 0, 4'd1};
    tbl[5]  = '{0, 1, 0, 1, 0, 4'd1};
    tbl[6]  = '{0, 1, 0, 0, 1, 4'd2};
    tbl[7]  = '{0, 1, 1, 0, 0, 4'd2};
    tbl[8]  = '{0, 1, 0, 1, 0, 4'd2};
    tbl[9]  = '{0, 0, 1, 0, 0, 4'd2};  // interrupts after the rise, no fall
    tbl[10] = '{0, 1, 0, 1, 0, 4'd2};
    tbl[11] = '{0, 1, 0, 0, 1, 4'd3};
    half_len = '0;
    pause = '0;
    for (int i = 0; i < 12; i++) begin
      exp_t row;
      reset  = tbl[i].rst;
      ce     = tbl[i].ce;
      resync = tbl[i].rs;
      row.r   = {CH{tbl[i].r}};
      row.f   = {CH{tbl[i].f}};
      row.p   = '0;
      row.cyc = {CH{tbl[i].cyc}};
      tick_x(1'b1, row);
    end
    reset = 1'b0; resync = 1'b0; ce = 1'b0;

    // ---- L = 8, ce every clk ----
    half_len = {4'd8, 4'd8};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_strobe(0, 1'b0, 40, n);  cmp("first_rise_ce", n, 1);
    wait_strobe(0, 1'b1, 40, n);  cmp("rise_to_fall_8", n, 8);
    ce = 1'b1;
    for (int i = 0; i < 39; i++) tick();
    cmp("cycles_after_48ce", 32'(cycles[CW-1:0]), 32'd3);

    // ---- half_len 8 -> 4 mid-cycle ----
    for (int i = 0; i < 3; i++) tick();
    half_len = {4'd4, 4'd4};
    wait_strobe(0, 1'b1, 40, n);  cmp("old_fall_still_8", n, 6);
    wait_strobe(0, 1'b0, 40, n);  cmp("old_period_16", n, 8);
    wait_strobe(0, 1'b1, 40, n);  cmp("new_high_4", n, 4);
    wait_strobe(0, 1'b0, 40, n);  cmp("new_low_4", n, 4);

    // ---- pause at cnt = 3 on channel 0 ----
    tick();
    tick();
    pause = 2'b01;
    wait_strobe(0, 1'b1, 40, n);  cmp("fall_after_pause", n, 2);
    s = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      s += int'(p2_h_r[0]) + int'(p2_h_f[0]);
    end
    cmp("paused_strobes", s, 0);
    cmp("paused_flag", 32'(paused[0]), 32'd1);
    pause = 2'b00;
    wait_strobe(0, 1'b0, 40, n);  cmp("resume_phase", n, 4);
    cmp("unpaused_flag", 32'(paused[0]), 32'd0);

    // ---- two channels L = 8 / 4, sparse ce, resync at arbitrary phase ----
    half_len = {4'd4, 4'd8};
    ce = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    for (int k = 0; k < 31; k++) begin
      ce = (k % 3 == 2);
      tick();
    end
    ce = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    tick();
    tick();
    ce = 1'b1;
    tick();
    cmp("resync_aligned_rise", 32'(p2_h_r), 32'd3);
    ce = 1'b0;
    tick();

    // ---- 4-bit cycles wrap, reset mid-period ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    half_len = '0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    cmp("cycles_15", 32'(cycles[CW-1:0]), 32'd15);
    tick();
    tick();
    cmp("cycles_wrap_0", 32'(cycles[CW-1:0]), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    cmp("reset_mid_period", {p2_h_r, p2_h_f, paused, cycles}, 32'd0);
    reset = 1'b0;

    // ---- randomised traffic against the model ----
    half_len = {4'd8, 4'd4};
    for (int i = 0; i < 400; i++) begin
      ce     = ($urandom_range(0, 2) != 0);
      resync = ($urandom_range(0, 39) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) pause = CH'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  half_len = (CH*HW)'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b0; resync = 1'b0; ce = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
